// File: rtl/phys_free_list_pkg.sv
// Shared sizing constants for the physical register free list and its users.
package phys_free_list_pkg;

  localparam int PHYS_REGS = 64;
  localparam int ARCH_REGS = 32;
  localparam int PHYS_W    = $clog2(PHYS_REGS);

endpackage

// File: rtl/phys_free_list_if.sv
// Rename/ROB-facing bundle of the free list: allocation, commit, recovery and flush.
interface phys_free_list_if
  import phys_free_list_pkg::*;
#(
  parameter int PHYS_W_P = PHYS_W
);

  logic                alloc_req;
  logic                alloc_gnt;
  logic [PHYS_W_P-1:0] alloc_pd;
  logic                free_avail;
  logic [PHYS_W_P:0]   free_count;
  logic                commit_valid;
  logic                commit_uses_rd;
  logic [PHYS_W_P-1:0] commit_pd_new;
  logic [PHYS_W_P-1:0] commit_pd_old;
  logic                recover_valid;
  logic                recover_uses_rd;
  logic [PHYS_W_P-1:0] recover_pd;
  logic                flush_valid;
  logic                dbl_free_err;

  modport master (
    output alloc_req, commit_valid, commit_uses_rd, commit_pd_new, commit_pd_old,
           recover_valid, recover_uses_rd, recover_pd, flush_valid,
    input  alloc_gnt, alloc_pd, free_avail, free_count, dbl_free_err
  );

  modport slave (
    input  alloc_req, commit_valid, commit_uses_rd, commit_pd_new, commit_pd_old,
           recover_valid, recover_uses_rd, recover_pd, flush_valid,
    output alloc_gnt, alloc_pd, free_avail, free_count, dbl_free_err
  );

endinterface

// File: rtl/phys_free_list_lsb_find.sv
// Parameterised lowest-set-bit finder; returns the index and whether any bit is set.
module lsb_find
  import phys_free_list_pkg::*;
#(
  parameter int N = PHYS_REGS,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scanning from the top down lets the lowest set bit win the last assignment.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/phys_free_list.sv
// Physical register free list with speculative and architectural free maps.
// Optional double-free detection is built when FREELIST_CHECK_EN is defined.
module phys_free_list
  import phys_free_list_pkg::*;
#(
  parameter int PHYS_REGS_P = PHYS_REGS,
  parameter int ARCH_REGS_P = ARCH_REGS,
  parameter int PHYS_W_P    = PHYS_W
) (
  input  logic             clk,
  input  logic             rst_n,
  phys_free_list_if.slave  fl
);

  localparam int CNT_W = PHYS_W_P + 1;
  localparam logic [PHYS_REGS_P-1:0] RESET_FREE = {PHYS_REGS_P{1'b1}} << ARCH_REGS_P;

  logic [PHYS_REGS_P-1:0] spec_free_q, spec_free_d;
  logic [PHYS_REGS_P-1:0] arch_free_q, arch_free_d;
  logic [CNT_W-1:0]       free_count_q, free_count_d;
  logic [CNT_W-1:0]       arch_pop;
  logic [PHYS_W_P-1:0]    alloc_pd;
  logic                   free_avail;
  logic                   alloc_gnt;
  logic                   commit_free;
  logic                   recover_free;

  lsb_find #(
    .N (PHYS_REGS_P),
    .W (PHYS_W_P)
  ) u_find (
    .vec (spec_free_q),
    .idx (alloc_pd),
    .any (free_avail)
  );

  assign alloc_gnt    = fl.alloc_req && free_avail && !fl.recover_valid && !fl.flush_valid;
  assign commit_free  = fl.commit_valid && fl.commit_uses_rd && (fl.commit_pd_old != '0);
  assign recover_free = fl.recover_valid && fl.recover_uses_rd && (fl.recover_pd != '0)
                        && !fl.flush_valid;

  always_comb begin
    arch_free_d = arch_free_q;
    if (commit_free) begin
      arch_free_d[fl.commit_pd_old] = 1'b1;
      arch_free_d[fl.commit_pd_new] = 1'b0;
    end
  end

  // Full popcount is only consumed on a flush; normal cycles count incrementally.
  always_comb begin
    arch_pop = '0;
    for (int i = 0; i < PHYS_REGS_P; i++) begin
      arch_pop = arch_pop + CNT_W'(arch_free_d[i]);
    end
  end

  always_comb begin
    spec_free_d  = spec_free_q;
    free_count_d = free_count_q - CNT_W'(alloc_gnt) + CNT_W'(commit_free)
                   + CNT_W'(recover_free);
    if (alloc_gnt) begin
      spec_free_d[alloc_pd] = 1'b0;
    end
    if (commit_free) begin
      spec_free_d[fl.commit_pd_old] = 1'b1;
    end
    if (recover_free) begin
      spec_free_d[fl.recover_pd] = 1'b1;
    end
    if (fl.flush_valid) begin
      spec_free_d  = arch_free_d;
      free_count_d = arch_pop;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spec_free_q  <= RESET_FREE;
      arch_free_q  <= RESET_FREE;
      free_count_q <= CNT_W'(PHYS_REGS_P - ARCH_REGS_P);
    end else begin
      spec_free_q  <= spec_free_d;
      arch_free_q  <= arch_free_d;
      free_count_q <= free_count_d;
    end
  end

  assign fl.alloc_gnt  = alloc_gnt;
  assign fl.alloc_pd   = alloc_pd;
  assign fl.free_avail = free_avail;
  assign fl.free_count = free_count_q;

`ifdef FREELIST_CHECK_EN
  logic dbl_free_err_q, dbl_free_err_d;
  logic dbl_hit;

  // Freeing a register that is already free means rename/ROB bookkeeping went wrong.
  always_comb begin
    dbl_hit = (commit_free && spec_free_q[fl.commit_pd_old])
              || (recover_free && spec_free_q[fl.recover_pd]);
    dbl_free_err_d = dbl_free_err_q || dbl_hit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dbl_free_err_q <= 1'b0;
    end else begin
      dbl_free_err_q <= dbl_free_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && dbl_hit) begin
      $error("phys_free_list: double free detected");
    end
  end

  assign fl.dbl_free_err = dbl_free_err_q;
`else
  assign fl.dbl_free_err = 1'b0;
`endif

endmodule

// File: tb/tb_phys_free_list.sv
// Directed scoreboard bench for phys_free_list (64 physical / 32 architectural regs).
module tb_phys_free_list;
  import phys_free_list_pkg::*;

  localparam int W = PHYS_W;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb_q[$];
  int   compared;
  int   mismatched;

  phys_free_list_if #(.PHYS_W_P(W)) fl_if ();

  phys_free_list #(
    .PHYS_REGS_P (PHYS_REGS),
    .ARCH_REGS_P (ARCH_REGS),
    .PHYS_W_P    (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fl    (fl_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic areq, input logic cv, input logic cuse,
                               input logic [W-1:0] cnew, input logic [W-1:0] cold,
                               input logic rv, input logic ruse, input logic [W-1:0] rpd,
                               input logic flush);
    fl_if.alloc_req       = areq;
    fl_if.commit_valid    = cv;
    fl_if.commit_uses_rd  = cuse;
    fl_if.commit_pd_new   = cnew;
    fl_if.commit_pd_old   = cold;
    fl_if.recover_valid   = rv;
    fl_if.recover_uses_rd = ruse;
    fl_if.recover_pd      = rpd;
    fl_if.flush_valid     = flush;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, '0, '0, 0, 0, '0, 0);
  endtask

  task automatic expect_out(input string tag, input logic [31:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    sb_q.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] observed);
    exp_t e;
    compared++;
    if (sb_q.size() == 0) begin
      mismatched++;
      $error("[TB] FAIL scoreboard_empty observed=%0d expected=none", observed);
    end else begin
      e = sb_q.pop_front();
      assert (observed === e.value) else begin
        mismatched++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", e.tag, observed, e.value);
      end
    end
  endtask

  task automatic probe(input string tag, input logic [31:0] observed, input logic [31:0] exp_v);
    expect_out(tag, exp_v);
    checkOutput(observed);
  endtask

  // Called right after driving inputs: checks combinational grant/pd, then count after the edge.
  task automatic cycle_check(input logic [31:0] exp_gnt, input bit check_pd,
                             input logic [31:0] exp_pd, input logic [31:0] exp_count);
    expect_out("alloc_gnt", exp_gnt);
    if (check_pd) expect_out("alloc_pd", exp_pd);
    expect_out("free_count", exp_count);
    #1;
    checkOutput(fl_if.alloc_gnt);
    if (check_pd) checkOutput(fl_if.alloc_pd);
    @(posedge clk);
    @(negedge clk);
    checkOutput(fl_if.free_count);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    idle();

    do_reset();
    #1;
    probe("reset_free_count", fl_if.free_count, 32);
    probe("reset_alloc_pd", fl_if.alloc_pd, 32);
    probe("reset_free_avail", fl_if.free_avail, 1);
    probe("reset_alloc_gnt", fl_if.alloc_gnt, 0);
    probe("reset_dbl_free_err", fl_if.dbl_free_err, 0);

    // Three back-to-back allocations hand out 32, 33, 34.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, '0, '0, 0, 0, '0, 0);
      cycle_check(1, 1, 32 + i, 31 - i);
    end
    idle();
    #1;
    probe("after3_alloc_pd", fl_if.alloc_pd, 35);

    // Drain the list, then a commit refills one register with no same-cycle bypass.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1, 0, 0, '0, '0, 0, 0, '0, 0);
      cycle_check(1, 1, 32 + i, 31 - i);
    end
    applyStimulus(1, 0, 0, '0, '0, 0, 0, '0, 0);
    #1;
    probe("empty_free_avail", fl_if.free_avail, 0);
    cycle_check(0, 0, 0, 0);
    applyStimulus(1, 1, 1, W'(40), W'(5), 0, 0, '0, 0);
    cycle_check(0, 0, 0, 1);
    idle();
    #1;
    probe("refill_alloc_pd", fl_if.alloc_pd, 5);
    probe("refill_free_avail", fl_if.free_avail, 1);
    @(negedge clk);
    applyStimulus(0, 0, 0, '0, '0, 0, 0, '0, 1);
    cycle_check(0, 0, 0, 32);
    idle();
    #1;
    probe("flush_after_drain_pd", fl_if.alloc_pd, 5);

    // Recovery frees the squashed destinations and blocks allocation while active.
    do_reset();
    applyStimulus(1, 0, 0, '0, '0, 0, 0, '0, 0);
    cycle_check(1, 1, 32, 31);
    applyStimulus(1, 0, 0, '0, '0, 0, 0, '0, 0);
    cycle_check(1, 1, 33, 30);
    applyStimulus(1, 0, 0, '0, '0, 1, 1, W'(33), 0);
    cycle_check(0, 0, 0, 31);
    applyStimulus(0, 0, 0, '0, '0, 1, 1, W'(32), 0);
    cycle_check(0, 0, 0, 32);
    idle();
    #1;
    probe("recover_alloc_pd", fl_if.alloc_pd, 32);

    // Flush restores the speculative map from the committed one.
    do_reset();
    applyStimulus(1, 0, 0, '0, '0, 0, 0, '0, 0);
    cycle_check(1, 1, 32, 31);
    applyStimulus(1, 1, 1, W'(32), W'(1), 0, 0, '0, 0);
    cycle_check(1, 1, 33, 31);
    applyStimulus(1, 0, 0, '0, '0, 0, 0, '0, 1);
    cycle_check(0, 0, 0, 32);
    idle();
    #1;
    probe("flush_alloc_pd", fl_if.alloc_pd, 1);
    @(negedge clk);
    applyStimulus(1, 0, 0, '0, '0, 0, 0, '0, 0);
    cycle_check(1, 1, 1, 31);
    idle();
    #1;
    probe("flush_next_pd", fl_if.alloc_pd, 33);

    // Simultaneous commit/recover frees, then alloc alongside a commit.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1, 0, 0, '0, '0, 0, 0, '0, 0);
      cycle_check(1, 1, 32 + i, 31 - i);
    end
    applyStimulus(1, 1, 1, W'(32), W'(7), 1, 1, W'(40), 0);
    cycle_check(0, 0, 0, 25);
    idle();
    #1;
    probe("dual_free_pd", fl_if.alloc_pd, 7);
    @(negedge clk);
    applyStimulus(1, 1, 1, W'(33), W'(8), 0, 0, '0, 0);
    cycle_check(1, 1, 7, 25);
    applyStimulus(1, 0, 0, '0, '0, 0, 0, '0, 0);
    cycle_check(1, 1, 8, 24);
    idle();
    #1;
    probe("recovered40_pd", fl_if.alloc_pd, 40);

    // Reset asserted together with flush: reset wins.
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(1, 0, 0, '0, '0, 0, 0, '0, 1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    #1;
    probe("rst_over_flush_count", fl_if.free_count, 32);
    probe("rst_over_flush_pd", fl_if.alloc_pd, 32);
    probe("rst_over_flush_avail", fl_if.free_avail, 1);

    // Freeing an already-free register.
    @(negedge clk);
    applyStimulus(0, 1, 1, W'(33), W'(50), 0, 0, '0, 0);
    cycle_check(0, 0, 0, 33);
    idle();
    @(negedge clk);
`ifdef FREELIST_CHECK_EN
    probe("dbl_free_set", fl_if.dbl_free_err, 1);
    @(negedge clk);
    probe("dbl_free_sticky", fl_if.dbl_free_err, 1);
`else
    probe("dbl_free_tied", fl_if.dbl_free_err, 0);
    @(negedge clk);
    probe("dbl_free_tied_later", fl_if.dbl_free_err, 0);
`endif
    do_reset();
    #1;
    probe("dbl_free_after_reset", fl_if.dbl_free_err, 0);

    if (sb_q.size() != 0) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
